pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the single-cycle and pipelined RV32I cores. It generalises the fixed "PC+4 or PC+imm" datapath. It adds a configurable reset vector, register-relative jumps (JALR), a stall hold, and a RAS_DEPTH-entry return-address stack (RAS) for call/return prediction. It sits at the front of the fetch stage and drives the instruction-memory address.

## Interface
- WIDTH, 32, address/data width in bits (≥ 8).
- RESET_VECTOR, 0, value loaded into pc on reset (WIDTH bits).
- INC, 4, sequential increment.
- RAS_DEPTH, 4, return-stack entries (power of two, ≥ 2).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- stall  in  1  when high, pc and RAS hold.
- pcsrc  in  2  next-pc select: 00 sequential, 01 branch, 10 jalr, 11 return.
- immop  in  WIDTH  sign-extended immediate.
- rs1  in  WIDTH  base register value for jalr.
- ras_push  in  1  call indicator: push pc+INC onto RAS.
- pc  out  WIDTH  current program counter (registered).
- pc_plus4  out  WIDTH  pc+INC (combinational, link value for JAL/JALR).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misaligned  out  1  pc[1:0] != 0 (combinational).

## Operation
- next_pc selection:
  - 00: pc + INC.
  - 01: pc + immop.
  - 10: (rs1 + immop) with bit 0 forced to 0.
  - 11: RAS top entry if ras_empty=0; otherwise pc + INC, and no pop occurs.
- All adds are WIDTH-bit, modulo 2^WIDTH. Overflow wraps silently with no flag.
- RAS is a circular stack: RAS_DEPTH entries, a log2(RAS_DEPTH)-bit top pointer, and a count of 0..RAS_DEPTH.
  - Push (ras_push=1, stall=0): writes pc_plus4 at top+1, advances top, count+1 saturating at RAS_DEPTH.
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop (pcsrc=11, ras_empty=0, stall=0): reads top, retreats top, count−1.
  - Push and pop in the same cycle: next_pc = old top entry; that entry is overwritten with pc_plus4. Top pointer and count are unchanged.
  - ras_push with pcsrc=00/01/10 is a normal push; next_pc follows pcsrc.
- stall=1: pc, RAS contents, pointer and count all hold. pcsrc and ras_push are ignored.
- rst=1 at a clock edge sets pc=RESET_VECTOR and count=0. It overrides stall and any push/pop in that cycle. RAS contents are don't-care.
- misaligned is status only. pc is never modified because of it.

## Timing
- pc, RAS pointer/count and RAS entries update on the rising clk edge. Latency from pcsrc/immop/rs1 to pc is 1 cycle.
- pc_plus4 and misaligned are combinational from pc.
- ras_empty and ras_full derive from the registered count. They change the cycle after the push/pop edge.
- The RAS top entry is visible to pcsrc=11 the cycle after the push that wrote it (push at edge N, return at edge N+1 is legal).
- Values after reset:
  - pc = RESET_VECTOR.
  - pc_plus4 = RESET_VECTOR + INC.
  - ras_empty = 1, ras_full = 0.
  - misaligned = RESET_VECTOR[1:0] != 0.
- Reset asserted mid-sequence (e.g. during a stall or back-to-back pushes) takes effect at the next edge. No partial state survives.

## Test plan
- Reset/sequential: RESET_VECTOR=0x100; hold rst 2 cycles, release, pcsrc=00 for 3 cycles -> pc = 0x100, 0x104, 0x108, 0x10C. ras_empty=1 throughout.
- Branch and wrap:
  - pc=0x200, immop=0xFFFFFFF0, pcsrc=01 -> pc=0x1F0 next cycle.
  - pc=0xFFFFFFFC, pcsrc=00 -> pc=0x0.
- JALR: rs1=0x1003, immop=0x4, pcsrc=10 -> pc=0x1006 (bit 0 cleared), misaligned=1.
- Call/return:
  - At pc=0x40, ras_push=1 with pcsrc=01, immop=0x100 -> pc=0x140, ras_empty=0.
  - Next cycle pcsrc=11 -> pc=0x44, then ras_empty=1.
  - pcsrc=11 on empty RAS -> pc advances by INC.
- Overflow and simultaneous push/pop (RAS_DEPTH=4):
  - Push 5 times, links A..E -> ras_full=1.
  - Then 4 returns -> pc = E, D, C, B; ras_empty=1 after the fourth.
  - With one entry X, assert push and pcsrc=11 together at pc=P -> pc=X, count unchanged. The next return yields P+4.
- Stall and reset priority:
  - stall=1 for 3 cycles with pcsrc=01 and ras_push=1 -> pc and count unchanged.
  - rst=1 together with stall=1 -> pc=RESET_VECTOR, ras_empty=1.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: selects next pc (sequential/branch/jalr/return) and keeps a
// circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] immop,
  input  logic [WIDTH-1:0] rs1,
  input  logic             ras_push,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned
);

  localparam int               PW      = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [PW:0]      CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]      CNT_MAX = (PW + 1)'(RAS_DEPTH);

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JR  = 2'b10;
  localparam logic [1:0] SRC_RET = 2'b11;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW:0]      count;

  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] jalr_sum;
  logic [PW-1:0]    top_up;
  logic             pop;

  assign pc_plus4   = pc + INC_W;
  assign misaligned = (pc[1:0] != 2'b00);
  assign ras_empty  = (count == '0);
  assign ras_full   = (count == CNT_MAX);
  assign jalr_sum   = rs1 + immop;
  assign top_up     = top + PTR_ONE;
  // A return on an empty stack degrades to a sequential fetch and must not pop.
  assign pop        = (pcsrc == SRC_RET) && !ras_empty;

  always_comb begin
    next_pc = pc_plus4;
    case (pcsrc)
      SRC_SEQ: next_pc = pc_plus4;
      SRC_BR:  next_pc = pc + immop;
      SRC_JR:  next_pc = {jalr_sum[WIDTH-1:1], 1'b0};
      SRC_RET: next_pc = pop ? ras[top] : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      top   <= '0;
      count <= '0;
    end else if (!stall) begin
      pc <= next_pc;
      if (ras_push && pop) begin
        // Return and call together: consume the top entry and replace it in place.
        ras[top] <= pc_plus4;
      end else if (ras_push) begin
        ras[top_up] <= pc_plus4;
        top         <= top_up;
        if (!ras_full) count <= count + CNT_ONE;
      end else if (pop) begin
        top   <= top - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
